// File: rtl/fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : fetch_decode
// Description : MSP430 instruction fetch/decode sequencer. Fetches opcode and
//               extension words, advances the PC and holds decoded fields
//               for the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_decode (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ready,
    input  logic [15:0] mem_rdata,
    input  logic [15:0] reg_PC_out,
    output logic [15:0] reg_PC_in,
    output logic [3:0]  reg_SA,
    output logic [3:0]  reg_DA,
    output logic [1:0]  As,
    output logic        Ad,
    output logic        BW,
    output logic [1:0]  fmt,
    output logic [3:0]  op,
    output logic [9:0]  jmp_off,
    output logic [15:0] src_ext,
    output logic [15:0] dst_ext,
    output logic        instr_valid,
    input  logic        exec_done,
    output logic        illegal
);

    localparam logic [1:0] FMT_DOUBLE  = 2'd0;
    localparam logic [1:0] FMT_SINGLE  = 2'd1;
    localparam logic [1:0] FMT_JUMP    = 2'd2;
    localparam logic [1:0] FMT_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        START   = 3'd0,
        FETCH   = 3'd1,
        SRC_EXT = 3'd2,
        DST_EXT = 3'd3,
        ISSUE   = 3'd4
    } state_t;

    state_t      state;
    logic [15:0] ir;
    logic        accept;
    logic [1:0]  ir_fmt;

    function automatic logic [1:0] word_fmt(input logic [15:0] w);
        logic [1:0] f;
        if (w[15:12] >= 4'd4)
            f = FMT_DOUBLE;
        else if (w[15:10] == 6'b000100)
            f = FMT_SINGLE;
        else if (w[15:13] == 3'b001)
            f = FMT_JUMP;
        else
            f = FMT_ILLEGAL;
        return f;
    endfunction

    // Constant-generator encodings (SA=3, or SA=2 with As>=2) never take a word.
    function automatic logic need_src(input logic [15:0] w);
        logic [1:0] f;
        logic [3:0] sa;
        logic [1:0] am;
        f  = word_fmt(w);
        sa = (f == FMT_DOUBLE) ? w[11:8] : w[3:0];
        am = w[5:4];
        return ((f == FMT_DOUBLE) || (f == FMT_SINGLE)) &&
               (((am == 2'b01) && (sa != 4'd3)) ||
                ((am == 2'b11) && (sa == 4'd0)));
    endfunction

    function automatic logic need_dst(input logic [15:0] w);
        return (word_fmt(w) == FMT_DOUBLE) && w[7];
    endfunction

    assign accept    = mem_req && mem_ready;
    assign mem_addr  = {reg_PC_out[15:1], 1'b0};
    assign reg_PC_in = accept ? (reg_PC_out + 16'd2) : reg_PC_out;
    assign ir_fmt    = word_fmt(ir);
    assign jmp_off   = ir[9:0];

    always_comb begin
        fmt    = 2'd0;
        op     = 4'd0;
        reg_SA = 4'd0;
        reg_DA = 4'd0;
        As     = 2'd0;
        Ad     = 1'b0;
        BW     = 1'b0;
        case (ir_fmt)
            FMT_DOUBLE: begin
                fmt    = FMT_DOUBLE;
                op     = ir[15:12];
                reg_SA = ir[11:8];
                Ad     = ir[7];
                BW     = ir[6];
                As     = ir[5:4];
                reg_DA = ir[3:0];
            end
            FMT_SINGLE: begin
                fmt    = FMT_SINGLE;
                op     = {1'b0, ir[9:7]};
                reg_SA = ir[3:0];
                reg_DA = ir[3:0];
                As     = ir[5:4];
                BW     = ir[6];
            end
            FMT_JUMP: begin
                fmt    = FMT_JUMP;
                op     = {1'b0, ir[12:10]};
            end
            default: begin
                fmt    = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= START;
            ir          <= 16'd0;
            src_ext     <= 16'd0;
            dst_ext     <= 16'd0;
            mem_req     <= 1'b0;
            instr_valid <= 1'b0;
            illegal     <= 1'b0;
        end else begin
            illegal <= 1'b0;
            case (state)
                START: begin
                    state   <= FETCH;
                    mem_req <= 1'b1;
                end
                FETCH: begin
                    if (accept) begin
                        ir <= mem_rdata;
                        if (word_fmt(mem_rdata) == FMT_ILLEGAL) begin
                            illegal <= 1'b1;
                        end else if (need_src(mem_rdata)) begin
                            state <= SRC_EXT;
                        end else if (need_dst(mem_rdata)) begin
                            state <= DST_EXT;
                        end else begin
                            state       <= ISSUE;
                            mem_req     <= 1'b0;
                            instr_valid <= 1'b1;
                        end
                    end
                end
                SRC_EXT: begin
                    if (accept) begin
                        src_ext <= mem_rdata;
                        if (need_dst(ir)) begin
                            state <= DST_EXT;
                        end else begin
                            state       <= ISSUE;
                            mem_req     <= 1'b0;
                            instr_valid <= 1'b1;
                        end
                    end
                end
                DST_EXT: begin
                    if (accept) begin
                        dst_ext     <= mem_rdata;
                        state       <= ISSUE;
                        mem_req     <= 1'b0;
                        instr_valid <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (exec_done) begin
                        state       <= FETCH;
                        mem_req     <= 1'b1;
                        instr_valid <= 1'b0;
                    end
                end
                default: begin
                    state       <= START;
                    mem_req     <= 1'b0;
                    instr_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_decode
// Description : Directed self-checking bench for fetch_decode with a small
//               program memory and a PC register model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ready = 1'b1;
    logic [15:0] mem_rdata;
    logic [15:0] reg_PC_out;
    logic [15:0] reg_PC_in;
    logic [3:0]  reg_SA;
    logic [3:0]  reg_DA;
    logic [1:0]  As;
    logic        Ad;
    logic        BW;
    logic [1:0]  fmt;
    logic [3:0]  op;
    logic [9:0]  jmp_off;
    logic [15:0] src_ext;
    logic [15:0] dst_ext;
    logic        instr_valid;
    logic        exec_done = 1'b0;
    logic        illegal;

    logic [15:0] mem [0:31];
    int n_checks = 0;
    int n_pass   = 0;

    fetch_decode dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rdata  (mem_rdata),
        .reg_PC_out (reg_PC_out),
        .reg_PC_in  (reg_PC_in),
        .reg_SA     (reg_SA),
        .reg_DA     (reg_DA),
        .As         (As),
        .Ad         (Ad),
        .BW         (BW),
        .fmt        (fmt),
        .op         (op),
        .jmp_off    (jmp_off),
        .src_ext    (src_ext),
        .dst_ext    (dst_ext),
        .instr_valid(instr_valid),
        .exec_done  (exec_done),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[5:1]];

    // PC register of reg_file: reset vector 0xFFFE, otherwise follows reg_PC_in.
    always @(posedge clk or negedge rst) begin
        if (!rst)
            reg_PC_out <= 16'hFFFE;
        else
            reg_PC_out <= reg_PC_in;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        mem[31] = 16'h5405;
        mem[0]  = 16'h4035;
        mem[1]  = 16'h1234;
        mem[2]  = 16'h4315;
        mem[3]  = 16'h4495;
        mem[4]  = 16'h0002;
        mem[5]  = 16'h0004;
        mem[6]  = 16'h3C05;
        mem[7]  = 16'h0000;
        mem[8]  = 16'h5405;

        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_mem_req",     16'(mem_req),     16'h0);
        chk("rst_instr_valid", 16'(instr_valid), 16'h0);
        chk("rst_illegal",     16'(illegal),     16'h0);
        chk("rst_src_ext",     src_ext,          16'h0000);
        chk("rst_dst_ext",     dst_ext,          16'h0000);
        chk("rst_pc_in",       reg_PC_in,        16'hFFFE);
        chk("rst_mem_addr",    mem_addr,         16'hFFFE);
        chk("rst_op",          16'(op),          16'h0);

        rst = 1'b1;
        #1 chk("start_mem_req", 16'(mem_req), 16'h0);
        @(negedge clk);
        chk("fetch_mem_req",  16'(mem_req), 16'h1);
        chk("fetch_mem_addr", mem_addr,     16'hFFFE);
        chk("fetch_pc_wrap",  reg_PC_in,    16'h0000);

        // ADD R4,R5
        cyc();
        chk("add_valid",  16'(instr_valid), 16'h1);
        chk("add_fmt",    16'(fmt),         16'h0);
        chk("add_op",     16'(op),          16'h5);
        chk("add_sa",     16'(reg_SA),      16'h4);
        chk("add_da",     16'(reg_DA),      16'h5);
        chk("add_as",     16'(As),          16'h0);
        chk("add_req",    16'(mem_req),     16'h0);
        chk("add_pc_hold", reg_PC_in,       16'h0000);
        exec_done = 1'b1;
        cyc();
        exec_done = 1'b0;
        chk("refetch_valid", 16'(instr_valid), 16'h0);
        chk("refetch_req",   16'(mem_req),     16'h1);
        chk("refetch_addr",  mem_addr,         16'h0000);

        // MOV #0x1234,R5
        cyc();
        chk("imm_ext_addr",  mem_addr,         16'h0002);
        chk("imm_ext_valid", 16'(instr_valid), 16'h0);
        cyc();
        chk("imm_valid",  16'(instr_valid), 16'h1);
        chk("imm_src",    src_ext,          16'h1234);
        chk("imm_as",     16'(As),          16'h3);
        chk("imm_sa",     16'(reg_SA),      16'h0);
        chk("imm_da",     16'(reg_DA),      16'h5);
        chk("imm_op",     16'(op),          16'h4);
        chk("imm_addr",   mem_addr,         16'h0004);
        exec_done = 1'b1;
        cyc();
        exec_done = 1'b0;

        // MOV #1,R5 via constant generator
        cyc();
        chk("cg_valid", 16'(instr_valid), 16'h1);
        chk("cg_as",    16'(As),          16'h1);
        chk("cg_sa",    16'(reg_SA),      16'h3);
        chk("cg_addr",  mem_addr,         16'h0006);
        exec_done = 1'b1;
        cyc();
        exec_done = 1'b0;

        // MOV 2(R4),4(R5) with a two-cycle stall on the source extension
        cyc();
        mem_ready = 1'b0;
        #1 chk("stall_pc_hold", reg_PC_in, 16'h0008);
        cyc();
        chk("stall_req",  16'(mem_req), 16'h1);
        chk("stall_addr", mem_addr,     16'h0008);
        cyc();
        chk("stall_addr2", mem_addr,    16'h0008);
        mem_ready = 1'b1;
        cyc();
        chk("dst_ext_addr", mem_addr, 16'h000A);
        cyc();
        chk("idx_valid", 16'(instr_valid), 16'h1);
        chk("idx_src",   src_ext,          16'h0002);
        chk("idx_dst",   dst_ext,          16'h0004);
        chk("idx_ad",    16'(Ad),          16'h1);
        chk("idx_sa",    16'(reg_SA),      16'h4);
        chk("idx_addr",  mem_addr,         16'h000C);
        exec_done = 1'b1;
        cyc();
        exec_done = 1'b0;

        // JMP +5
        cyc();
        chk("jmp_valid", 16'(instr_valid), 16'h1);
        chk("jmp_fmt",   16'(fmt),         16'h2);
        chk("jmp_op",    16'(op),          16'h7);
        chk("jmp_off",   16'(jmp_off),     16'h0005);
        chk("jmp_sa",    16'(reg_SA),      16'h0);
        exec_done = 1'b1;
        cyc();
        exec_done = 1'b0;

        // Illegal 0x0000
        cyc();
        chk("ill_pulse", 16'(illegal),     16'h1);
        chk("ill_valid", 16'(instr_valid), 16'h0);
        chk("ill_req",   16'(mem_req),     16'h1);
        chk("ill_addr",  mem_addr,         16'h0010);
        cyc();
        chk("ill_once",   16'(illegal),     16'h0);
        chk("post_valid", 16'(instr_valid), 16'h1);
        chk("post_op",    16'(op),          16'h5);

        // Reset during ISSUE
        rst = 1'b0;
        #1;
        chk("abort_valid", 16'(instr_valid), 16'h0);
        chk("abort_req",   16'(mem_req),     16'h0);
        @(negedge clk);
        rst = 1'b1;
        #1 chk("restart_req", 16'(mem_req), 16'h0);
        @(negedge clk);
        chk("restart_fetch_req",  16'(mem_req), 16'h1);
        chk("restart_fetch_addr", mem_addr,     16'hFFFE);
        cyc();
        chk("restart_valid", 16'(instr_valid), 16'h1);
        chk("restart_op",    16'(op),          16'h5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_decode.md
# fetch_decode

Instruction fetch and decode sequencer for the MSP430 core, directly upstream of `reg_file`. It fetches the opcode word at the current PC and any source or destination extension words. It drives the incremented PC into the register file's PC input and decodes the opcode into register addresses, addressing modes and operation fields. The decoded instruction is held for the execute stage until that stage signals completion.

## Interface
Parameters:
- none

Ports:
- `clk`  input  1  system clock, all state on rising edge
- `rst`  input  1  reset, asynchronous assert, active-low
- `mem_req`  output  1  fetch request to program memory
- `mem_addr`  output  16  word address, equals `{reg_PC_out[15:1],1'b0}`
- `mem_ready`  input  1  `mem_rdata` valid; a word is accepted when `mem_req && mem_ready`
- `mem_rdata`  input  16  fetched word
- `reg_PC_out`  input  16  current PC from `reg_file`
- `reg_PC_in`  output  16  next PC to `reg_file`
- `reg_SA`, `reg_DA`  output  4  source and destination register addresses
- `As`  output  2  source addressing mode
- `Ad`  output  1  destination addressing mode
- `BW`  output  1  byte/word flag
- `fmt`  output  2  instruction format: 0 = double-operand, 1 = single-operand, 2 = jump
- `op`  output  4  opcode: fmt0 `ir[15:12]`, fmt1 `{1'b0,ir[9:7]}`, fmt2 `{1'b0,ir[12:10]}`
- `jmp_off`  output  10  `ir[9:0]` (fmt2)
- `src_ext`, `dst_ext`  output  16  captured extension words
- `instr_valid`  output  1  decoded instruction presented to execute
- `exec_done`  input  1  execute finished the presented instruction
- `illegal`  output  1  one-cycle pulse on an illegal opcode

## Operation
- States: START, FETCH, SRC_EXT, DST_EXT, ISSUE.
- Reset (`rst` low): state START, `ir`=0, `src_ext`=`dst_ext`=0. All outputs are 0 except `reg_PC_in` and `mem_addr`, which stay combinational from `reg_PC_out`.
- **START**
  - Lasts exactly one cycle after `rst` rises, so `reg_file` loads the reset vector.
  - Goes to FETCH.
- **FETCH**
  - `mem_req`=1.
  - On accept: `ir`←`mem_rdata`.
  - Decode the word:
    - fmt0 if `rdata[15:12]`≥4.
    - fmt1 if `rdata[15:10]`==6'b000100.
    - fmt2 if `rdata[15:13]`==3'b001.
    - Anything else is illegal.
  - Illegal opcode: pulse `illegal` next cycle, stay in FETCH.
  - Legal opcode: go to SRC_EXT if a source extension is needed, else DST_EXT if a destination extension is needed, else ISSUE.
- **Source extension needed** (fmt0 and fmt1) when either holds:
  - `As`==01 and `SA`≠3 (indexed or absolute).
  - `As`==11 and `SA`==0 (immediate).
  - Constant-generator cases (`SA`=2 with `As`≥10, or `SA`=3) need no extension.
- **Destination extension needed**: fmt0 with `Ad`==1.
- **SRC_EXT / DST_EXT**
  - `mem_req`=1.
  - On accept: capture `mem_rdata` into `src_ext` or `dst_ext` respectively.
  - SRC_EXT goes to DST_EXT if a destination extension is needed, else ISSUE.
  - DST_EXT goes to ISSUE.
- **ISSUE**
  - `instr_valid`=1; all decoded outputs held stable.
  - `exec_done`=1 returns to FETCH next cycle.
- **Field mapping by format**
  - fmt0: `reg_SA`=`ir[11:8]`, `Ad`=`ir[7]`, `BW`=`ir[6]`, `As`=`ir[5:4]`, `reg_DA`=`ir[3:0]`.
  - fmt1: `reg_SA`=`reg_DA`=`ir[3:0]`, `As`=`ir[5:4]`, `BW`=`ir[6]`, `Ad`=0.
  - fmt2: `reg_SA`=`reg_DA`=0, `As`=0, `Ad`=0, `BW`=0.
  - Outside ISSUE, decoded outputs show the last `ir` and are don't-care to consumers.
- **PC**
  - `reg_PC_in` = `reg_PC_out`+2 (16-bit wrap, 0xFFFE→0x0000) in any cycle where a word is accepted.
  - Otherwise `reg_PC_in` = `reg_PC_out`.
  - Execute-stage PC writes go through `reg_file` `RW` and take priority there.

## Timing
- One word per accept; maximum fetch rate is one word per cycle while `mem_ready`=1.
- Minimum latency from opcode accept to `instr_valid`: 1 cycle (no extension), 2 cycles (one extension), 3 cycles (two).
- `mem_ready` low stalls: `mem_req` held, `mem_addr` stable, PC not incremented.
- `exec_done` outside ISSUE is ignored.
- `rst` low mid-fetch or mid-ISSUE aborts immediately to START; `instr_valid` and `mem_req` drop asynchronously.

## Test plan
- Release reset with `reg_PC_out`=0xFFFE from `reg_file` → START for 1 cycle, then `mem_req`=1 with `mem_addr`=0xFFFE.
- Fetch 0x5405 (ADD R4,R5), `mem_ready`=1 → `reg_PC_in`=PC+2 on accept. Next cycle `instr_valid`=1, `fmt`=0, `op`=5, `reg_SA`=4, `reg_DA`=5, `As`=0. `exec_done` → FETCH.
- Fetch 0x4035, 0x1234 (MOV #0x1234,R5) → `src_ext`=0x1234, `As`=3, `reg_SA`=0, 2 words consumed. Then fetch 0x4315 (MOV #1,R5) → no extension fetched, `As`=1, `reg_SA`=3.
- Fetch 0x4495, 0x0002, 0x0004 (MOV 2(R4),4(R5)) with `mem_ready` low for 2 cycles during the second word → `src_ext`=2, `dst_ext`=4, `Ad`=1, PC advanced by exactly 6.
- Fetch 0x3C05 → `fmt`=2, `op`=7, `jmp_off`=5. Fetch 0x0000 → `illegal` pulses once, `instr_valid` stays 0, next fetch at PC+2.
- Drive `rst` low during ISSUE → `instr_valid`=0 immediately. After release, START, then refetch.
